// File: rtl/zedern_pkg.sv
// Shared definitions for the zedern RV32IM execute stage: RV32M funct3
// encodings, writeback-source encodings, EX state enum and datapath width.
package zedern_pkg;

    // Datapath width (XLEN); only 32 is supported.
    localparam int RV_XLEN = 32;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    // Writeback source select, carried through EX untouched
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_CSR = 2'd3;

    typedef enum logic [1:0] {
        EX_IDLE = 2'd0,
        EX_BUSY = 2'd1,
        EX_DONE = 2'd2
    } ex_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned engine: shift-add multiply / restoring divide, one result
// bit per cycle. Operands arrive as magnitudes; signs are handled by the parent.
// Optional MULDIV_EARLY_OUT_EN: multiply finishes once remaining multiplier bits are zero.
module muldiv_iter
    import zedern_pkg::*;
#(
    parameter int W     = RV_XLEN,
    parameter int ITERS = RV_XLEN
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic         abort,
    input  logic         is_div,
    input  logic [W-1:0] a,      // multiplicand / dividend
    input  logic [W-1:0] b,      // multiplier / divisor
    output logic         busy,
    output logic         done,   // final iteration happens on this cycle's edge
    output logic [W-1:0] lo,     // product low / quotient
    output logic [W-1:0] hi      // product high / remainder
);
    localparam int CW = $clog2(ITERS + 1);

    logic [CW-1:0]  cnt;
    logic           div_q;
    logic [2*W-1:0] acc, mcand, acc_d, mcand_d;
    logic [W-1:0]   mplier, mplier_d;
    logic [W:0]     rem_sh, dvs, diff;
    logic           early;

    // One iteration of the active algorithm; for divide, mplier holds the
    // dividend shifting out on top while quotient bits shift in below.
    always_comb begin
        acc_d    = acc;
        mcand_d  = mcand;
        mplier_d = mplier;
        rem_sh   = {acc[W-1:0], mplier[W-1]};
        dvs      = {1'b0, mcand[W-1:0]};
        diff     = rem_sh - dvs;
        early    = 1'b0;
        if (div_q) begin
            if (rem_sh >= dvs) begin
                acc_d    = {{W{1'b0}}, diff[W-1:0]};
                mplier_d = {mplier[W-2:0], 1'b1};
            end else begin
                acc_d    = {{W{1'b0}}, rem_sh[W-1:0]};
                mplier_d = {mplier[W-2:0], 1'b0};
            end
        end else begin
            if (mplier[0]) acc_d = acc + mcand;
            mcand_d  = mcand << 1;
            mplier_d = mplier >> 1;
`ifdef MULDIV_EARLY_OUT_EN
            early = (mplier_d == '0);
`endif
        end
        busy = (cnt != '0);
        done = busy && ((cnt == CW'(1)) || early);
        lo   = div_q ? mplier : acc[W-1:0];
        hi   = div_q ? acc[W-1:0] : acc[2*W-1:W];
    end

    // Engine registers: load on start, iterate while busy, abort clears the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            div_q  <= 1'b0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (abort) begin
            cnt <= '0;
        end else if (start) begin
            cnt    <= CW'(ITERS);
            div_q  <= is_div;
            acc    <= '0;
            mcand  <= {{W{1'b0}}, is_div ? b : a};
            mplier <= is_div ? a : b;
        end else if (busy) begin
            acc    <= acc_d;
            mcand  <= mcand_d;
            mplier <= mplier_d;
            cnt    <= done ? '0 : cnt - CW'(1);
        end
    end

endmodule

// File: rtl/execute_muldiv_stage.sv
// EX back end: registers the EX/MEM boundary, passes base-ALU results in one
// cycle and sequences RV32M ops through muldiv_iter, stalling upstream meanwhile.
// Optional MULDIV_EARLY_OUT_EN: early multiply completion (zero multiplier skips the engine).
module execute_muldiv_stage
    import zedern_pkg::*;
#(
    parameter int XLEN      = RV_XLEN,
    parameter int ITER_BITS = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            flush,
    input  logic [XLEN-1:0] rs1_val,
    input  logic [XLEN-1:0] rs2_val,
    input  logic [XLEN-1:0] alu_result,
    input  logic            is_muldiv,
    input  logic [2:0]      md_funct3,
    input  logic [4:0]      rd_addr,
    input  logic            reg_write,
    input  logic [1:0]      wb_mux,
    output logic            stall,
    output logic [XLEN-1:0] alu_out,
    output logic [4:0]      rd_addr_out,
    output logic            reg_write_out,
    output logic [1:0]      wb_mux_out
);
    localparam int ITERS = XLEN / ITER_BITS;

    ex_state_e       state_q, state_d;
    logic            a_signed, b_signed, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;
    logic            div_zero, div_ovf, fast_now;
    logic [XLEN-1:0] fast_val;
    logic            accept, start, abort;
    logic            eng_busy, eng_done;
    logic [XLEN-1:0] eng_lo, eng_hi;

    logic [2:0]      op_q;
    logic            prod_neg_q, rem_neg_q, fast_q;
    logic [XLEN-1:0] fast_val_q;

    logic [2*XLEN-1:0] prod, prod_fix;
    logic [XLEN-1:0]   quo_fix, rem_fix, md_result;

    // Operand signedness, magnitudes and the results that skip the engine.
    always_comb begin
        a_signed = (md_funct3 == F3_MULH) || (md_funct3 == F3_MULHSU) ||
                   (md_funct3 == F3_DIV)  || (md_funct3 == F3_REM);
        b_signed = (md_funct3 == F3_MULH) || (md_funct3 == F3_DIV) ||
                   (md_funct3 == F3_REM);
        a_neg    = a_signed && rs1_val[XLEN-1];
        b_neg    = b_signed && rs2_val[XLEN-1];
        a_mag    = a_neg ? -rs1_val : rs1_val;
        b_mag    = b_neg ? -rs2_val : rs2_val;
        div_zero = md_funct3[2] && (rs2_val == '0);
        div_ovf  = ((md_funct3 == F3_DIV) || (md_funct3 == F3_REM)) &&
                   (rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (rs2_val == '1);
        fast_now = div_zero || div_ovf;
        if (md_funct3[1]) fast_val = div_ovf ? '0 : rs1_val;
        else              fast_val = div_ovf ? {1'b1, {(XLEN-1){1'b0}}} : '1;
`ifdef MULDIV_EARLY_OUT_EN
        if (!md_funct3[2] && (rs2_val == '0)) begin
            fast_now = 1'b1;
            fast_val = '0;
        end
`endif
    end

    // Next state, stall and engine control; flush overrides everything.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        accept  = 1'b0;
        start   = 1'b0;
        abort   = 1'b0;
        if (flush) begin
            state_d = EX_IDLE;
            abort   = 1'b1;
        end else begin
            case (state_q)
                EX_IDLE: if (in_valid && is_muldiv) begin
                    stall   = 1'b1;
                    accept  = 1'b1;
                    start   = !fast_now;
                    state_d = fast_now ? EX_DONE : EX_BUSY;
                end
                EX_BUSY: begin
                    stall = 1'b1;
                    if (eng_done || !eng_busy) state_d = EX_DONE;
                end
                EX_DONE: state_d = EX_IDLE;
                default: state_d = EX_IDLE;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= EX_IDLE;
        else        state_q <= state_d;
    end

    // Latch the op and sign fix-up flags when an RV32M instruction is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q       <= F3_MUL;
            prod_neg_q <= 1'b0;
            rem_neg_q  <= 1'b0;
            fast_q     <= 1'b0;
            fast_val_q <= '0;
        end else if (accept) begin
            op_q       <= md_funct3;
            prod_neg_q <= a_neg ^ b_neg;
            rem_neg_q  <= a_neg;
            fast_q     <= fast_now;
            fast_val_q <= fast_val;
        end
    end

    muldiv_iter #(.W(XLEN), .ITERS(ITERS)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .abort  (abort),
        .is_div (md_funct3[2]),
        .a      (a_mag),
        .b      (b_mag),
        .busy   (eng_busy),
        .done   (eng_done),
        .lo     (eng_lo),
        .hi     (eng_hi)
    );

    // Sign fix-up and result selection, consumed in DONE.
    always_comb begin
        prod     = {eng_hi, eng_lo};
        prod_fix = prod_neg_q ? -prod : prod;
        quo_fix  = prod_neg_q ? -eng_lo : eng_lo;
        rem_fix  = rem_neg_q ? -eng_hi : eng_hi;
        case (op_q)
            F3_MUL:                        md_result = prod_fix[XLEN-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU:  md_result = prod_fix[2*XLEN-1:XLEN];
            F3_DIV, F3_DIVU:               md_result = quo_fix;
            default:                       md_result = rem_fix;
        endcase
        if (fast_q) md_result = fast_val_q;
    end

    // EX/MEM register: bubbles only clear reg_write_out, data fields hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_out       <= '0;
            rd_addr_out   <= '0;
            reg_write_out <= 1'b0;
            wb_mux_out    <= '0;
        end else if (flush) begin
            reg_write_out <= 1'b0;
        end else begin
            case (state_q)
                EX_IDLE: if (in_valid && !is_muldiv) begin
                    alu_out       <= alu_result;
                    rd_addr_out   <= rd_addr;
                    reg_write_out <= reg_write;
                    wb_mux_out    <= wb_mux;
                end else begin
                    reg_write_out <= 1'b0;
                end
                EX_DONE: begin
                    alu_out       <= md_result;
                    rd_addr_out   <= rd_addr;
                    reg_write_out <= reg_write;
                    wb_mux_out    <= wb_mux;
                end
                default: reg_write_out <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_execute_muldiv_stage.sv
// Directed bench for execute_muldiv_stage with a result scoreboard.
// Expected stall lengths follow MULDIV_EARLY_OUT_EN when it is defined.
module tb_execute_muldiv_stage;
    import zedern_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0, flush = 1'b0, is_muldiv = 1'b0, reg_write = 1'b0;
    logic [31:0] rs1_val = '0, rs2_val = '0, alu_result = '0;
    logic [2:0]  md_funct3 = '0;
    logic [4:0]  rd_addr = '0;
    logic [1:0]  wb_mux = '0;
    logic        stall, reg_write_out;
    logic [31:0] alu_out;
    logic [4:0]  rd_addr_out;
    logic [1:0]  wb_mux_out;

    typedef struct {
        string       name;
        logic [31:0] d;
        logic [4:0]  rd;
        logic [1:0]  wb;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad = 0;

    always #5 clk = ~clk;

    execute_muldiv_stage dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .flush         (flush),
        .rs1_val       (rs1_val),
        .rs2_val       (rs2_val),
        .alu_result    (alu_result),
        .is_muldiv     (is_muldiv),
        .md_funct3     (md_funct3),
        .rd_addr       (rd_addr),
        .reg_write     (reg_write),
        .wb_mux        (wb_mux),
        .stall         (stall),
        .alu_out       (alu_out),
        .rd_addr_out   (rd_addr_out),
        .reg_write_out (reg_write_out),
        .wb_mux_out    (wb_mux_out)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected multiply stall length from the multiplier magnitude.
    function automatic int mul_stall(input logic [31:0] bm);
`ifdef MULDIV_EARLY_OUT_EN
        int msb;
        msb = -1;
        for (int i = 0; i < 32; i++) if (bm[i]) msb = i;
        return (msb < 0) ? 1 : 2 + msb;
`else
        return 33;
`endif
    endfunction

    // Every write leaving the stage must match the oldest expected result.
    always @(negedge clk) begin
        if (reg_write_out === 1'b1) begin
            total++;
            assert (sbq.size() != 0) else begin
                bad++;
                $error("FAIL spurious_write observed=%h expected=none", alu_out);
            end
            if (sbq.size() != 0) begin
                exp_t e;
                e = sbq.pop_front();
                chk({e.name, "_data"}, alu_out, e.d);
                chk({e.name, "_rd"}, {27'b0, rd_addr_out}, {27'b0, e.rd});
                chk({e.name, "_wb"}, {30'b0, wb_mux_out}, {30'b0, e.wb});
            end
        end
    end

    task automatic drive(input logic md, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] alu,
                         input logic [4:0] rd, input logic [1:0] wb);
        in_valid   = 1'b1;
        is_muldiv  = md;
        md_funct3  = f3;
        rs1_val    = a;
        rs2_val    = b;
        alu_result = alu;
        rd_addr    = rd;
        wb_mux     = wb;
        reg_write  = 1'b1;
    endtask

    // Issue one instruction, hold it while stalled, check stall length.
    task automatic run_op(input string name, input logic md, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu,
                          input logic [4:0] rd, input logic [1:0] wb,
                          input logic [31:0] exp_d, input int exp_stall);
        int n;
        bit ok;
        @(negedge clk);
        drive(md, f3, a, b, alu, rd, wb);
        sbq.push_back('{name, exp_d, rd, wb});
        n  = 0;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            #1;
            if (!stall) begin
                ok = 1'b1;
                break;
            end
            n++;
            @(negedge clk);
        end
        if (!ok) n = -1;
        chk({name, "_stall"}, n, exp_stall);
        @(negedge clk);
        in_valid  = 1'b0;
        is_muldiv = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        #1;
        chk("rst_alu_out", alu_out, 32'h0);
        chk("rst_rd", {27'b0, rd_addr_out}, 32'h0);
        chk("rst_rw", {31'b0, reg_write_out}, 32'h0);
        chk("rst_wb", {30'b0, wb_mux_out}, 32'h0);
        chk("rst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("add", 1'b0, 3'd0, 32'h1, 32'h2, 32'h12345678, 5'd5, 2'b01, 32'h12345678, 0);
        run_op("mul_7_m3", 1'b1, F3_MUL, 32'd7, 32'hFFFFFFFD, 32'h0, 5'd6, 2'b00,
               32'hFFFFFFEB, mul_stall(32'hFFFFFFFD));
        run_op("mul_5_3", 1'b1, F3_MUL, 32'd5, 32'd3, 32'h0, 5'd7, 2'b10, 32'd15, mul_stall(32'd3));
        run_op("mulhu", 1'b1, F3_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd8, 2'b00,
               32'hFFFFFFFE, mul_stall(32'hFFFFFFFF));
        run_op("mulh", 1'b1, F3_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd9, 2'b00,
               32'h00000000, mul_stall(32'd1));
        run_op("mulhsu", 1'b1, F3_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 5'd10, 2'b00,
               32'hFFFFFFFF, mul_stall(32'hFFFFFFFF));
        run_op("div_m7_2", 1'b1, F3_DIV, 32'hFFFFFFF9, 32'd2, 32'h0, 5'd11, 2'b00, 32'hFFFFFFFD, 33);
        run_op("rem_m7_2", 1'b1, F3_REM, 32'hFFFFFFF9, 32'd2, 32'h0, 5'd12, 2'b11, 32'hFFFFFFFF, 33);
        run_op("div_7_m2", 1'b1, F3_DIV, 32'd7, 32'hFFFFFFFE, 32'h0, 5'd13, 2'b00, 32'hFFFFFFFD, 33);
        run_op("rem_7_m2", 1'b1, F3_REM, 32'd7, 32'hFFFFFFFE, 32'h0, 5'd14, 2'b00, 32'd1, 33);
        run_op("divu_100_7", 1'b1, F3_DIVU, 32'd100, 32'd7, 32'h0, 5'd15, 2'b00, 32'd14, 33);
        run_op("remu_100_7", 1'b1, F3_REMU, 32'd100, 32'd7, 32'h0, 5'd16, 2'b00, 32'd2, 33);
        run_op("divu_9_0", 1'b1, F3_DIVU, 32'd9, 32'd0, 32'h0, 5'd17, 2'b00, 32'hFFFFFFFF, 1);
        run_op("rem_7_0", 1'b1, F3_REM, 32'd7, 32'd0, 32'h0, 5'd18, 2'b00, 32'd7, 1);
        run_op("rem_ovf", 1'b1, F3_REM, 32'h80000000, 32'hFFFFFFFF, 32'h0, 5'd19, 2'b00, 32'h0, 1);
        run_op("div_ovf", 1'b1, F3_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h0, 5'd20, 2'b00,
               32'h80000000, 1);
        run_op("mul_x_0", 1'b1, F3_MUL, 32'd1234, 32'd0, 32'h0, 5'd21, 2'b00, 32'd0, mul_stall(32'd0));

        // Flush at iteration 10 of a DIVU
        @(negedge clk);
        drive(1'b1, F3_DIVU, 32'd1000, 32'd3, 32'h0, 5'd22, 2'b00);
        #1;
        chk("flush_accept_stall", {31'b0, stall}, 32'h1);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        #1;
        chk("flush_cycle_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_next_stall", {31'b0, stall}, 32'h0);
        chk("flush_bubble", {31'b0, reg_write_out}, 32'h0);
        run_op("add_after_flush", 1'b0, 3'd0, 32'h0, 32'h0, 32'h0BADF00D, 5'd23, 2'b01,
               32'h0BADF00D, 0);

        // Flush together with a new RV32M instruction: not accepted
        @(negedge clk);
        drive(1'b1, F3_MUL, 32'd3, 32'd3, 32'h0, 5'd24, 2'b00);
        flush = 1'b1;
        #1;
        chk("flush_new_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("flush_new_idle", {31'b0, stall}, 32'h0);
        chk("flush_new_bubble", {31'b0, reg_write_out}, 32'h0);

        // Asynchronous reset in the middle of BUSY
        @(negedge clk);
        drive(1'b1, F3_MUL, 32'd2, 32'd3, 32'h0, 5'd25, 2'b00);
        repeat (2) @(negedge clk);
        #2;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("arst_alu_out", alu_out, 32'h0);
        chk("arst_rd", {27'b0, rd_addr_out}, 32'h0);
        chk("arst_wb", {30'b0, wb_mux_out}, 32'h0);
        chk("arst_stall", {31'b0, stall}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op("mul_after_rst", 1'b1, F3_MUL, 32'd2, 32'd3, 32'h0, 5'd26, 2'b10, 32'd6, mul_stall(32'd3));

        repeat (3) @(negedge clk);
        total++;
        assert (sbq.size() == 0) else begin
            bad++;
            $error("FAIL sb_drain observed=%0d expected=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
